// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART command arbiter.
// Holds the FSM state encoding, the word widths and the default timeout.
package uart_arb_pkg;

    localparam int CMD_W       = 16;
    localparam int BYTE_W      = 8;
    localparam int TIMEOUT_DEF = 4096;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_TX  = 2'd2,
        WAIT_RSP = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic              err;
        logic [BYTE_W-1:0] data;
    } rsp_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// searching upward with wrap-around.
module rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_onehot_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               any_o
);

    localparam logic [IDX_W:0] NR_W = (IDX_W+1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     off;
    logic [IDX_W:0]       sum;
    logic                 found;

    // Doubling the vector lets the rotation by ptr be a plain index.
    assign dbl = {req_i, req_i};

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        assign rot[gi] = dbl[{1'b0, ptr_i} + (IDX_W+1)'(gi)];
    end

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                off   = IDX_W'(k);
            end
        end
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= NR_W) begin
            sum = sum - NR_W;
        end
    end

    assign grant_idx_o = sum[IDX_W-1:0];
    assign any_o       = found;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign grant_onehot_o[gi] = found && (grant_idx_o == IDX_W'(gi));
    end

endmodule

// File: rtl/uart_cmd_arbiter.sv
// Round-robin arbiter sharing one UART command port among NUM_REQ masters,
// routing read responses (or timeouts) back to the issuing requester.
module uart_cmd_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int RD_BIT  = 15,
    localparam int IDX_W  = $clog2(NUM_REQ),
    localparam int TMR_W  = $clog2(TIMEOUT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ*CMD_W-1:0] req_cmd_i,
    input  logic [NUM_REQ-1:0]       req_vld_i,
    output logic [NUM_REQ-1:0]       req_rdy_o,
    output logic [NUM_REQ-1:0]       rsp_vld_o,
    output logic [BYTE_W-1:0]        rsp_data_o,
    output logic                     rsp_err_o,
    output logic [CMD_W-1:0]         uart_cmd_o,
    output logic                     uart_cmd_vld_o,
    input  logic                     uart_cmd_rdy_i,
    input  logic                     uart_read_rdy_i,
    input  logic [BYTE_W-1:0]        uart_read_data_i,
    output logic                     busy_o,
    output logic [IDX_W-1:0]         grant_id_o,
    output logic                     stray_rsp_o
);

    localparam logic [1:0] ST_IDLE     = IDLE;
    localparam logic [1:0] ST_ISSUE    = ISSUE;
    localparam logic [1:0] ST_WAIT_TX  = WAIT_TX;
    localparam logic [1:0] ST_WAIT_RSP = WAIT_RSP;

    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

    logic [1:0]         state_q, state_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0] req_rdy_q, req_rdy_d;
    logic [NUM_REQ-1:0] rsp_vld_q, rsp_vld_d;
    rsp_t               rsp_q, rsp_d;
    logic               uart_cmd_vld_q, uart_cmd_vld_d;
    logic               busy_q, busy_d;
    logic               stray_q, stray_d;
    logic               seen_low_q, seen_low_d;
    logic [TMR_W-1:0]   timer_q, timer_d;

    logic [IDX_W-1:0]   ptr;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic               tmr_done;

    assign ptr = (last_grant_q == LAST_INIT) ? '0 : last_grant_q + 1'b1;

    rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_pick (
        .req_i          (req_vld_i),
        .ptr_i          (ptr),
        .grant_onehot_o (pick_onehot),
        .grant_idx_o    (pick_idx),
        .any_o          (pick_any)
    );

    assign gnt_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_q;
    assign tmr_done   = (timer_q == TMR_LAST);

    always_comb begin
        state_d        = state_q;
        cmd_d          = cmd_q;
        grant_id_d     = grant_id_q;
        last_grant_d   = last_grant_q;
        req_rdy_d      = '0;
        rsp_vld_d      = '0;
        rsp_d          = rsp_q;
        uart_cmd_vld_d = uart_cmd_vld_q;
        stray_d        = stray_q;
        seen_low_d     = seen_low_q;
        timer_d        = timer_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    cmd_d          = req_cmd_i[pick_idx*CMD_W +: CMD_W];
                    grant_id_d     = pick_idx;
                    last_grant_d   = pick_idx;
                    req_rdy_d      = pick_onehot;
                    uart_cmd_vld_d = 1'b1;
                    state_d        = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (uart_cmd_vld_q && uart_cmd_rdy_i) begin
                    uart_cmd_vld_d = 1'b0;
                    seen_low_d     = 1'b0;
                    state_d        = ST_WAIT_TX;
                end
            end
            ST_WAIT_TX: begin
                // The UART must be seen busy before its ready counts as TX done.
                if (!uart_cmd_rdy_i) begin
                    seen_low_d = 1'b1;
                end
                if (seen_low_q && uart_cmd_rdy_i) begin
                    state_d = cmd_q[RD_BIT] ? ST_WAIT_RSP : ST_IDLE;
                end else if (tmr_done) begin
                    if (cmd_q[RD_BIT]) begin
                        rsp_vld_d  = gnt_onehot;
                        rsp_d.err  = 1'b1;
                        rsp_d.data = '0;
                    end
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_WAIT_RSP: begin
                // A byte arriving on the timeout cycle still wins.
                if (uart_read_rdy_i) begin
                    rsp_vld_d  = gnt_onehot;
                    rsp_d.err  = 1'b0;
                    rsp_d.data = uart_read_data_i;
                    state_d    = ST_IDLE;
                end else if (tmr_done) begin
                    rsp_vld_d  = gnt_onehot;
                    rsp_d.err  = 1'b1;
                    rsp_d.data = '0;
                    state_d    = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (uart_read_rdy_i && (state_q != ST_WAIT_RSP)) begin
            stray_d = 1'b1;
        end
        if (state_d != state_q) begin
            timer_d = '0;
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cmd_q          <= '0;
            grant_id_q     <= '0;
            last_grant_q   <= LAST_INIT;
            req_rdy_q      <= '0;
            rsp_vld_q      <= '0;
            rsp_q          <= '0;
            uart_cmd_vld_q <= 1'b0;
            busy_q         <= 1'b0;
            stray_q        <= 1'b0;
            seen_low_q     <= 1'b0;
            timer_q        <= '0;
        end else begin
            state_q        <= state_d;
            cmd_q          <= cmd_d;
            grant_id_q     <= grant_id_d;
            last_grant_q   <= last_grant_d;
            req_rdy_q      <= req_rdy_d;
            rsp_vld_q      <= rsp_vld_d;
            rsp_q          <= rsp_d;
            uart_cmd_vld_q <= uart_cmd_vld_d;
            busy_q         <= busy_d;
            stray_q        <= stray_d;
            seen_low_q     <= seen_low_d;
            timer_q        <= timer_d;
        end
    end

    assign req_rdy_o      = req_rdy_q;
    assign rsp_vld_o      = rsp_vld_q;
    assign rsp_data_o     = rsp_q.data;
    assign rsp_err_o      = rsp_q.err;
    assign uart_cmd_o     = cmd_q;
    assign uart_cmd_vld_o = uart_cmd_vld_q;
    assign busy_o         = busy_q;
    assign grant_id_o     = grant_id_q;
    assign stray_rsp_o    = stray_q;

endmodule

// File: tb/tb_uart_cmd_arbiter.sv
// Directed and randomized bench for uart_cmd_arbiter; expected grants and
// responses come from a round-robin / timeout reference model.
module tb_uart_cmd_arbiter;

    localparam int NR  = 4;
    localparam int TO  = 64;
    localparam int RDB = 15;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR*16-1:0] req_cmd = '0;
    logic [NR-1:0]   req_vld = '0;
    logic [NR-1:0]   req_rdy;
    logic [NR-1:0]   rsp_vld;
    logic [7:0]      rsp_data;
    logic            rsp_err;
    logic [15:0]     uart_cmd;
    logic            uart_cmd_vld;
    logic            uart_cmd_rdy = 1'b1;
    logic            uart_read_rdy = 1'b0;
    logic [7:0]      uart_read_data = '0;
    logic            busy;
    logic [1:0]      grant_id;
    logic            stray_rsp;

    uart_cmd_arbiter #(
        .NUM_REQ (NR),
        .TIMEOUT (TO),
        .RD_BIT  (RDB)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_cmd_i        (req_cmd),
        .req_vld_i        (req_vld),
        .req_rdy_o        (req_rdy),
        .rsp_vld_o        (rsp_vld),
        .rsp_data_o       (rsp_data),
        .rsp_err_o        (rsp_err),
        .uart_cmd_o       (uart_cmd),
        .uart_cmd_vld_o   (uart_cmd_vld),
        .uart_cmd_rdy_i   (uart_cmd_rdy),
        .uart_read_rdy_i  (uart_read_rdy),
        .uart_read_data_i (uart_read_data),
        .busy_o           (busy),
        .grant_id_o       (grant_id),
        .stray_rsp_o      (stray_rsp)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int rsp_cnt = 0;
    int model_last = NR - 1;
    logic [15:0] cmds [NR];

    // Every response pulse seen on the bus, for "no response" checks.
    always @(negedge clk) begin
        if (rsp_vld != '0) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference round-robin: first pending requester after the last grant.
    function automatic int rr_expect(input logic [NR-1:0] vld, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (vld[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic present(input logic [NR-1:0] mask);
        for (int r = 0; r < NR; r++) req_cmd[r*16 +: 16] = cmds[r];
        req_vld = mask;
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_req_rdy"}, req_rdy, 0);
        chk({p, "_rsp_vld"}, rsp_vld, 0);
        chk({p, "_rsp_data"}, rsp_data, 0);
        chk({p, "_rsp_err"}, rsp_err, 0);
        chk({p, "_uart_cmd"}, uart_cmd, 0);
        chk({p, "_uart_cmd_vld"}, uart_cmd_vld, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_grant_id"}, grant_id, 0);
        chk({p, "_stray"}, stray_rsp, 0);
    endtask

    // Waits for the accept pulse (arbiter must be idle), checks it against the
    // model, then lets the UART take the command. Returns the observed grant.
    task automatic grant_step(output int g);
        int waited;
        int exp_g;
        exp_g = rr_expect(req_vld, model_last);
        for (waited = 1; waited <= 20; waited++) begin
            tick();
            if (req_rdy != '0) break;
        end
        chk("accept_latency", waited, 1);
        chk("req_rdy_onehot", req_rdy, 1 << exp_g);
        chk("grant_id", grant_id, exp_g);
        chk("uart_cmd", uart_cmd, cmds[exp_g]);
        chk("uart_cmd_vld", uart_cmd_vld, 1);
        chk("busy_issue", busy, 1);
        g = int'(grant_id);
        model_last = exp_g;
        tick();
        chk("req_rdy_pulse", req_rdy, 0);
        chk("uart_cmd_vld_drop", uart_cmd_vld, 0);
    endtask

    task automatic uart_tx(input int lo, input bit is_read);
        uart_cmd_rdy = 1'b0;
        repeat (lo) tick();
        chk("busy_wait_tx", busy, 1);
        uart_cmd_rdy = 1'b1;
        tick();
        chk("busy_after_tx", busy, is_read);
    endtask

    task automatic read_rsp(input int idx, input int d, input bit send, input logic [7:0] b);
        int exp_lat, lat;
        bit exp_err, got;
        logic [7:0] exp_b, obs_b;
        logic [NR-1:0] obs_vld;
        bit obs_e;
        if (send && d <= TO - 1) begin
            exp_lat = d + 1; exp_err = 1'b0; exp_b = b;
        end else begin
            exp_lat = TO; exp_err = 1'b1; exp_b = 8'h00;
        end
        got = 1'b0; lat = 0; obs_vld = '0; obs_b = '0; obs_e = 1'b0;
        for (int t = 1; t <= TO + 4; t++) begin
            if (send && (t - 1 == d)) begin
                uart_read_rdy = 1'b1;
                uart_read_data = b;
            end
            tick();
            uart_read_rdy = 1'b0;
            if (rsp_vld != '0) begin
                got = 1'b1; lat = t; obs_vld = rsp_vld; obs_b = rsp_data; obs_e = rsp_err;
                break;
            end
        end
        chk("rsp_seen", got, 1);
        chk("rsp_latency", lat, exp_lat);
        chk("rsp_vld_onehot", obs_vld, 1 << idx);
        chk("rsp_data", obs_b, exp_b);
        chk("rsp_err", obs_e, exp_err);
        chk("busy_after_rsp", busy, 0);
        tick();
        chk("rsp_vld_pulse", rsp_vld, 0);
    endtask

    initial begin
        int g, c0, mask, lo, d;
        bit rd, send;
        logic [7:0] b;
        for (int r = 0; r < NR; r++) cmds[r] = '0;

        repeat (3) tick();
        chk_reset("reset");
        rst_n = 1'b1;
        tick();

        // Single write from requester 0, UART busy for 22 cycles.
        cmds[0] = 16'h1234;
        c0 = rsp_cnt;
        present(4'b0001);
        grant_step(g);
        req_vld = '0;
        uart_tx(22, 1'b0);
        tick();
        chk("write_no_rsp", rsp_cnt - c0, 0);
        $display("txn write: req %0d cmd 0x1234", g);

        // Read from requester 2, byte 0xA5 ten cycles after TX done.
        cmds[2] = 16'h8055;
        present(4'b0100);
        grant_step(g);
        req_vld = '0;
        uart_tx(5, 1'b1);
        read_rsp(2, 10, 1'b1, 8'hA5);
        chk("no_stray_after_read", stray_rsp, 0);
        $display("txn read: req %0d cmd 0x8055 byte 0xA5", g);

        // Fairness: all requesters pending continuously with writes.
        for (int r = 0; r < NR; r++) cmds[r] = 16'(r * 16'h0111);
        c0 = rsp_cnt;
        present(4'b1111);
        begin
            int start;
            start = (model_last + 1) % NR;
            for (int i = 0; i < 2 * NR; i++) begin
                grant_step(g);
                chk("fair_order", g, (start + i) % NR);
                cmds[g] = 16'($urandom) & 16'h7FFF;
                req_cmd[g*16 +: 16] = cmds[g];
                uart_tx(int'($urandom_range(1, 6)), 1'b0);
                $display("txn fair: grant %0d", g);
            end
        end
        req_vld = '0;
        tick();
        chk("fair_no_rsp", rsp_cnt - c0, 0);

        // Read timeout on requester 1.
        cmds[1] = 16'h8001;
        present(4'b0010);
        grant_step(g);
        req_vld = '0;
        uart_tx(4, 1'b1);
        read_rsp(1, 0, 1'b0, 8'h00);
        $display("txn timeout: req %0d cmd 0x8001", g);

        // Stray byte in IDLE.
        chk("stray_before", stray_rsp, 0);
        c0 = rsp_cnt;
        uart_read_rdy = 1'b1;
        uart_read_data = 8'h3C;
        tick();
        uart_read_rdy = 1'b0;
        tick();
        chk("stray_set", stray_rsp, 1);
        chk("stray_no_rsp", rsp_cnt - c0, 0);
        chk("stray_busy", busy, 0);
        $display("txn stray: byte 0x3C in IDLE");

        // Byte and timeout on the same cycle: the byte wins.
        cmds[3] = 16'h80C3;
        present(4'b1000);
        grant_step(g);
        req_vld = '0;
        uart_tx(2, 1'b1);
        read_rsp(3, TO - 1, 1'b1, 8'h5A);
        $display("txn tie: req %0d byte 0x5A at timeout edge", g);

        // Randomized mixes of pending requesters, reads and writes.
        for (int n = 0; n < 12; n++) begin
            mask = int'($urandom_range(1, 15));
            for (int r = 0; r < NR; r++) cmds[r] = 16'($urandom);
            c0 = rsp_cnt;
            present(4'(mask));
            grant_step(g);
            req_vld = '0;
            rd = cmds[model_last][RDB];
            lo = int'($urandom_range(1, 8));
            uart_tx(lo, rd);
            if (rd) begin
                send = ($urandom_range(0, 3) != 0);
                d = int'($urandom_range(0, TO - 1));
                b = 8'($urandom);
                read_rsp(model_last, d, send, b);
                chk("rand_rsp_count", rsp_cnt - c0, 1);
            end else begin
                send = 1'b0; d = 0; b = 8'h00;
                tick();
                chk("rand_write_no_rsp", rsp_cnt - c0, 0);
            end
            $display("txn rand %0d: mask 0x%0h grant %0d cmd 0x%04h read %0d send %0d delay %0d",
                     n, mask, g, cmds[model_last], rd, send, d);
        end

        // Asynchronous reset in the middle of WAIT_RSP.
        cmds[2] = 16'h8077;
        present(4'b0100);
        grant_step(g);
        req_vld = '0;
        uart_tx(3, 1'b1);
        repeat (5) tick();
        chk("busy_before_reset", busy, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset("async_reset");
        model_last = NR - 1;
        c0 = rsp_cnt;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (TO + 5) tick();
        chk("no_rsp_after_reset", rsp_cnt - c0, 0);
        for (int r = 0; r < NR; r++) cmds[r] = 16'h0F00 + 16'(r);
        present(4'b1111);
        grant_step(g);
        req_vld = '0;
        chk("post_reset_grant", g, 0);
        uart_tx(2, 1'b0);
        $display("txn post-reset: grant %0d", g);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_arbiter.md
# uart_cmd_arbiter

Shares one UART command/response port among NUM_REQ requesters. Each requester submits a 16-bit command; the arbiter grants requesters round-robin and forwards one command at a time to the UART. For read commands it routes the returned byte, or a timeout error, back to the requester that issued it. The block sits between the register/command masters and the UART TX/RX datapath.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT, 4096, cycles allowed for the TX-done and read-response waits (≥ 64)
- RD_BIT, 15, bit of the command that marks a read (1 = read, expects one response byte)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_cmd  in  NUM_REQ*16  command of requester i at [16*i+15:16*i]
- req_vld  in  NUM_REQ  requester i has a command pending
- req_rdy  out  NUM_REQ  one-cycle accept pulse to the granted requester
- rsp_vld  out  NUM_REQ  one-cycle response pulse to the originating requester
- rsp_data  out  8  response byte, valid with rsp_vld
- rsp_err  out  1  response is a timeout, valid with rsp_vld
- uart_cmd  out  16  command to the UART
- uart_cmd_vld  out  1  command valid to the UART
- uart_cmd_rdy  in  1  UART idle and able to accept a command
- uart_read_rdy  in  1  UART received-byte strobe
- uart_read_data  in  8  UART received byte
- busy  out  1  arbiter not in IDLE
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester
- stray_rsp  out  1  sticky flag: a received byte arrived outside WAIT_RSP

## Operation
- FSM states: IDLE, ISSUE, WAIT_TX, WAIT_RSP.
- IDLE, any req_vld set:
  - Pick the first set bit searching from ptr = (last_grant+1) mod NUM_REQ upward, with wrap-around.
  - Latch req_cmd of that requester into cmd_q and set grant_id.
  - Pulse req_rdy[g] for one cycle, then go to ISSUE.
- Round-robin pointer:
  - last_grant resets to NUM_REQ-1, so requester 0 has first priority after reset.
  - last_grant updates only on a grant.
- ISSUE:
  - uart_cmd = cmd_q and uart_cmd_vld = 1; hold both until uart_cmd_vld && uart_cmd_rdy.
  - On the handshake, drop uart_cmd_vld the next cycle, clear the timer, go to WAIT_TX.
- WAIT_TX:
  - Set seen_low when uart_cmd_rdy = 0.
  - Exit when seen_low && uart_cmd_rdy = 1: go to WAIT_RSP if cmd_q[RD_BIT] = 1, else IDLE.
  - Timer reaching TIMEOUT-1: if a read, pulse rsp_vld[g] with rsp_err = 1 and rsp_data = 0x00; go to IDLE in either case.
- WAIT_RSP:
  - uart_read_rdy = 1: pulse rsp_vld[g], rsp_data = uart_read_data, rsp_err = 0, go to IDLE.
  - Timer reaching TIMEOUT-1: pulse rsp_vld[g], rsp_data = 0x00, rsp_err = 1, go to IDLE.
  - If the byte strobe and the timeout occur in the same cycle, the byte wins.
- Received-byte strobe in any other state: the byte is dropped and stray_rsp is set until reset.
- Timer: $clog2(TIMEOUT) bits; clears on every state entry; increments in WAIT_TX and WAIT_RSP only; never wraps.
- Write commands produce no rsp_vld.

## Timing
- Reset values:
  - req_rdy = 0, rsp_vld = 0, rsp_data = 0x00, rsp_err = 0
  - uart_cmd = 0x0000, uart_cmd_vld = 0
  - busy = 0, grant_id = 0, stray_rsp = 0, state IDLE
- Reset mid-operation: immediate return to IDLE. The in-flight command is abandoned and no response is issued.
- All outputs are registered.
- Accept latency:
  - req_vld sampled high in IDLE at cycle N gives req_rdy[g] = 1 and uart_cmd_vld = 1 at N+1.
  - The requester holds req_vld/req_cmd until it sees req_rdy. It may present a new command from N+2.
- Response latency: rsp_vld is asserted the cycle after the uart_read_rdy sample.
- Minimum spacing between grants: one cycle in IDLE after returning.
- busy = 1 in all states except IDLE.

## Structure
- Package uart_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT_TX, WAIT_RSP}
  - CMD_W = 16, BYTE_W = 8
  - the default TIMEOUT constant
- Sub-module rr_pick: combinational round-robin selector taking (req_vld, ptr) and returning (grant_onehot, grant_idx, any). It is instanced once.

## Test plan
- Single write: req_vld[0], cmd 0x1234; UART model drops uart_cmd_rdy for 22 cycles.
  - Expect req_rdy[0] one cycle later and uart_cmd = 0x1234 while uart_cmd_vld is high.
  - Expect a return to IDLE and no rsp_vld.
- Read: requester 2 sends cmd 0x8055; model returns byte 0xA5 10 cycles after TX done.
  - Expect rsp_vld[2] for one cycle with rsp_data = 0xA5 and rsp_err = 0.
- Fairness: all 4 req_vld held high continuously with write commands.
  - Expect grant order 0, 1, 2, 3, 0, 1, ...
  - Expect no requester granted twice while another waits.
- Timeout: read cmd 0x8001 from requester 1 with no received byte.
  - Expect rsp_vld[1] with rsp_err = 1 and rsp_data = 0x00 exactly TIMEOUT cycles after entering WAIT_RSP.
- Boundary: uart_read_rdy pulses in IDLE.
  - Expect stray_rsp = 1 and no rsp_vld.
  - Also check the received byte winning over a timeout in the same cycle.
- Async reset asserted during WAIT_RSP.
  - Expect all outputs at reset values immediately and no response after release.
  - Expect the next grant to go to requester 0.
